// File: rtl/adler32_par.sv
// Adler-32 over a beat stream with val/rdy input; PAR_BYTES bytes are folded per clock, MSB first.
// Define ADLER32_PAR_SEED_EN to add seed_i, which loads {s2, s1} on start_i.
module adler32_par #(
  parameter int unsigned DATA_BYTES = 4,
  parameter int unsigned PAR_BYTES  = 1,
  parameter int unsigned NUM_WD     = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start_i,
`ifdef ADLER32_PAR_SEED_EN
  input  logic [31:0]             seed_i,
`endif
  input  logic                    val_i,
  output logic                    rdy_o,
  input  logic [8*DATA_BYTES-1:0] dat_i,
  input  logic [NUM_WD-1:0]       num_i,
  input  logic                    lst_i,
  output logic                    busy_o,
  output logic                    val_o,
  output logic                    done_o,
  output logic [31:0]             dat_o
);

  localparam int unsigned CntW = $clog2(DATA_BYTES + 1);
  localparam logic [16:0] Mod  = 17'd65521;

  typedef enum logic [1:0] {StIdle, StActv, StProc} state_e;

  state_e                  state_q, state_d;
  logic [15:0]             s1_q, s1_d, s2_q, s2_d;
  logic [8*DATA_BYTES-1:0] buf_q, buf_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic                    lst_q, lst_d;
  logic                    val_q, val_d;
  logic                    done_q, done_d;
  logic [31:0]             init_val;
  logic [15:0]             fold_s1, fold_s2;

`ifdef ADLER32_PAR_SEED_EN
  assign init_val = seed_i;
`else
  assign init_val = 32'h0000_0001;
`endif

  // Byte steps chained combinationally; bytes at or past the remaining count pass s1/s2 through.
  always_comb begin
    logic [16:0] t1;
    logic [17:0] t2;
    logic [15:0] a1, a2;
    logic [7:0]  d;
    a1 = s1_q;
    a2 = s2_q;
    t1 = '0;
    t2 = '0;
    d  = '0;
    for (int j = 0; j < int'(PAR_BYTES); j++) begin
      d  = buf_q[8*DATA_BYTES-1-8*j -: 8];
      t1 = {1'b0, a1} + {9'b0, d};
      if (t1 >= Mod) t1 = t1 - Mod;
      t2 = {2'b00, a2} + {2'b00, t1[15:0]};
      if (t2 >= 18'd131042)     t2 = t2 - 18'd131042;
      else if (t2 >= 18'd65521) t2 = t2 - 18'd65521;
      if (j < int'(cnt_q)) begin
        a1 = t1[15:0];
        a2 = t2[15:0];
      end
    end
    fold_s1 = a1;
    fold_s2 = a2;
  end

  always_comb begin
    state_d = state_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    lst_d   = lst_q;
    val_d   = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StActv;
          s1_d    = init_val[15:0];
          s2_d    = init_val[31:16];
        end
      end
      StActv: begin
        // Restart wins over a beat offered in the same cycle; that beat is dropped.
        if (start_i) begin
          s1_d = init_val[15:0];
          s2_d = init_val[31:16];
        end else if (val_i) begin
          buf_d   = dat_i;
          cnt_d   = CntW'(num_i) + CntW'(1);
          lst_d   = lst_i;
          state_d = StProc;
        end
      end
      StProc: begin
        s1_d  = fold_s1;
        s2_d  = fold_s2;
        buf_d = buf_q << (8 * PAR_BYTES);
        if (cnt_q <= CntW'(PAR_BYTES)) begin
          cnt_d   = '0;
          val_d   = 1'b1;
          done_d  = lst_q;
          state_d = lst_q ? StIdle : StActv;
        end else begin
          cnt_d = cnt_q - CntW'(PAR_BYTES);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      s1_q    <= '0;
      s2_q    <= '0;
      buf_q   <= '0;
      cnt_q   <= '0;
      lst_q   <= 1'b0;
      val_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      lst_q   <= lst_d;
      val_q   <= val_d;
      done_q  <= done_d;
    end
  end

  assign rdy_o  = (state_q == StActv);
  assign busy_o = (state_q != StIdle);
  assign val_o  = val_q;
  assign done_o = done_q;
  assign dat_o  = {s2_q, s1_q};

endmodule

// File: tb/tb_adler32_par.sv
// Scoreboard bench for adler32_par: three instances (4/1, 4/2, 8/4 bytes per beat/clock).
// Driver pushes model results into per-instance queues; a negedge monitor pops on val_o.
module tb_adler32_par;

  typedef struct {
    logic [31:0] d;
    bit          done;
    int          cyc;
  } exp_t;

  logic             clk;
  logic             rstn;
  logic [2:0]       start, val, lst;
  logic [2:0][63:0] dat;
  logic [2:0][2:0]  num;
  logic [2:0]       rdy, busy, valo, done;
  logic [2:0][31:0] dato;
`ifdef ADLER32_PAR_SEED_EN
  logic [2:0][31:0] seed;
`endif

  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  int unsigned s1m [3];
  int unsigned s2m [3];
  exp_t        q0[$];
  exp_t        q1[$];
  exp_t        q2[$];

  adler32_par #(.DATA_BYTES(4), .PAR_BYTES(1)) u_dut0 (
    .clk(clk), .rstn(rstn), .start_i(start[0]),
`ifdef ADLER32_PAR_SEED_EN
    .seed_i(seed[0]),
`endif
    .val_i(val[0]), .rdy_o(rdy[0]), .dat_i(dat[0][63:32]), .num_i(num[0][1:0]),
    .lst_i(lst[0]), .busy_o(busy[0]), .val_o(valo[0]), .done_o(done[0]), .dat_o(dato[0])
  );

  adler32_par #(.DATA_BYTES(4), .PAR_BYTES(2)) u_dut1 (
    .clk(clk), .rstn(rstn), .start_i(start[1]),
`ifdef ADLER32_PAR_SEED_EN
    .seed_i(seed[1]),
`endif
    .val_i(val[1]), .rdy_o(rdy[1]), .dat_i(dat[1][63:32]), .num_i(num[1][1:0]),
    .lst_i(lst[1]), .busy_o(busy[1]), .val_o(valo[1]), .done_o(done[1]), .dat_o(dato[1])
  );

  adler32_par #(.DATA_BYTES(8), .PAR_BYTES(4)) u_dut2 (
    .clk(clk), .rstn(rstn), .start_i(start[2]),
`ifdef ADLER32_PAR_SEED_EN
    .seed_i(seed[2]),
`endif
    .val_i(val[2]), .rdy_o(rdy[2]), .dat_i(dat[2]), .num_i(num[2]),
    .lst_i(lst[2]), .busy_o(busy[2]), .val_o(valo[2]), .done_o(done[2]), .dat_o(dato[2])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got 0x%08h, required 0x%08h", nm, k, act, exp);
    end
  endtask

  function automatic int qsize(input int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic push_exp(input int k, input exp_t e);
    case (k)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic pop_exp(input int k, output bit ok, output exp_t e);
    ok = 1'b0;
    e  = '{d: 32'h0, done: 1'b0, cyc: 0};
    if (qsize(k) > 0) begin
      ok = 1'b1;
      case (k)
        0:       e = q0.pop_front();
        1:       e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
    end
  endtask

  // Monitor: every val_o must match the oldest queued expectation.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin : mon
      bit   ok;
      exp_t e;
      if (rstn && valo[k]) begin
        pop_exp(k, ok, e);
        if (!ok) begin
          chk("unexpected_val_o", k, 32'(valo[k]), 32'h0);
        end else begin
          chk("dat_o", k, dato[k], e.d);
          chk("done_o", k, 32'(done[k]), 32'(e.done));
          chk("val_cycle", k, 32'(cyc), 32'(e.cyc));
          chk("rdy_at_val", k, 32'(rdy[k]), 32'(!e.done));
        end
      end else if (rstn && done[k]) begin
        chk("done_without_val", k, 32'(done[k]), 32'h0);
      end
    end
  end

  task automatic wait_rdy(input int k, output int w);
    w = 0;
    while (!rdy[k] && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!rdy[k]) begin
      checks++;
      errors++;
      $display("FAIL rdy_timeout dut%0d: rdy_o=0 after %0d cycles, required 1", k, w);
      w = -1;
    end
  endtask

  task automatic do_start(input int k, input logic [31:0] sd);
`ifdef ADLER32_PAR_SEED_EN
    seed[k] = sd;
`endif
    start[k] = 1'b1;
    @(negedge clk);
    start[k] = 1'b0;
    s1m[k] = 32'(sd[15:0]);
    s2m[k] = 32'(sd[31:16]);
  endtask

  // Offers one left-aligned beat, holds it until accepted, and queues the model result.
  task automatic send(input int k, input logic [63:0] d, input int nb, input bit l,
                      input int gap);
    int   w, n, par;
    exp_t e;
    logic [7:0] b;
    par = (k == 0) ? 1 : (k == 1) ? 2 : 4;
    n   = (nb + par) / par;
    val[k] = 1'b1;
    dat[k] = d;
    num[k] = 3'(nb);
    lst[k] = l;
    wait_rdy(k, w);
    if (w >= 0) begin
      if (gap >= 0) chk("rdy_gap", k, 32'(w), 32'(gap));
      for (int i = 0; i <= nb; i++) begin
        b = d[63-8*i -: 8];
        s1m[k] = (s1m[k] + 32'(b)) % 65521;
        s2m[k] = (s2m[k] + s1m[k]) % 65521;
      end
      e.d    = {s2m[k][15:0], s1m[k][15:0]};
      e.done = l;
      e.cyc  = cyc + 1 + n;
      push_exp(k, e);
      @(negedge clk);
    end
    val[k] = 1'b0;
    lst[k] = 1'b0;
  endtask

  task automatic drain(input int k);
    int w;
    w = 0;
    while (qsize(k) != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("sb_drain", k, 32'(qsize(k)), 32'h0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int w;
    clk   = 1'b0;
    rstn  = 1'b1;
    start = '0;
    val   = '0;
    lst   = '0;
    dat   = '0;
    num   = '0;
`ifdef ADLER32_PAR_SEED_EN
    seed  = {3{32'h0000_0001}};
`endif
    #1 rstn = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("reset_dat_o", k, dato[k], 32'h0);
      chk("reset_rdy_o", k, 32'(rdy[k]), 32'h0);
      chk("reset_busy_o", k, 32'(busy[k]), 32'h0);
      chk("reset_val_o", k, 32'(valo[k]), 32'h0);
      chk("reset_done_o", k, 32'(done[k]), 32'h0);
    end
    rstn = 1'b1;
    @(negedge clk);

    // Single byte "a", junk in masked bytes.
    do_start(0, 32'h1);
    send(0, {32'h6112_3456, 32'h0}, 0, 1'b1, -1);
    drain(0);
    chk("a_final", 0, dato[0], 32'h0062_0062);
    chk("idle_after_done", 0, 32'(busy[0]), 32'h0);

    // "Wikipedia" at two bytes per clock.
    do_start(1, 32'h1);
    send(1, {32'h5769_6B69, 32'h0}, 3, 1'b0, -1);
    send(1, {32'h7065_6469, 32'h0}, 3, 1'b0, 2);
    send(1, {32'h61DE_ADBE, 32'h0}, 0, 1'b1, 2);
    drain(1);
    chk("wikipedia_final", 1, dato[1], 32'h11E6_0398);

    // "abc" in an 8-byte beat at four bytes per clock.
    do_start(2, 32'h1);
    send(2, 64'h6162_63A5_5AC3_3C99, 2, 1'b1, -1);
    drain(2);
    chk("abc_final", 2, dato[2], 32'h024D_0127);

    // 6000 bytes of 0xFF, val_i held high.
    do_start(0, 32'h1);
    for (int i = 0; i < 1500; i++)
      send(0, {32'hFFFF_FFFF, 32'h0}, 3, (i == 1499), (i == 0) ? -1 : 4);
    drain(0);

    // 0xFF stream with varying partial beats on the wide instance.
    do_start(2, 32'h1);
    for (int i = 0; i < 200; i++)
      send(2, 64'hFFFF_FFFF_FFFF_FFFF, i % 8, (i == 199),
           (i == 0) ? -1 : (((i - 1) % 8) + 4) / 4);
    drain(2);

    // Restart in ACTV together with an offered beat: the beat is dropped.
    do_start(0, 32'h1);
    send(0, {32'h5769_6B69, 32'h0}, 3, 1'b0, -1);
    wait_rdy(0, w);
    start[0] = 1'b1;
    val[0]   = 1'b1;
    dat[0]   = {32'h7065_6469, 32'h0};
    num[0]   = 3'd3;
    @(negedge clk);
    start[0] = 1'b0;
    val[0]   = 1'b0;
    s1m[0]   = 1;
    s2m[0]   = 0;
    chk("abort_stays_actv", 0, 32'(rdy[0]), 32'h1);
    send(0, {32'h61AB_CDEF, 32'h0}, 0, 1'b1, -1);
    drain(0);
    chk("abort_final", 0, dato[0], 32'h0062_0062);

    // Asynchronous reset during PROC.
    do_start(0, 32'h1);
    val[0] = 1'b1;
    dat[0] = {32'h5769_6B69, 32'h0};
    num[0] = 3'd3;
    @(negedge clk);
    val[0] = 1'b0;
    chk("proc_busy", 0, 32'(busy[0]), 32'h1);
    chk("proc_rdy", 0, 32'(rdy[0]), 32'h0);
    rstn = 1'b0;
    #1;
    chk("midreset_dat_o", 0, dato[0], 32'h0);
    chk("midreset_busy_o", 0, 32'(busy[0]), 32'h0);
    chk("midreset_rdy_o", 0, 32'(rdy[0]), 32'h0);
    chk("midreset_val_o", 0, 32'(valo[0]), 32'h0);
    chk("midreset_done_o", 0, 32'(done[0]), 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    chk("after_reset_idle", 0, 32'(busy[0]), 32'h0);

`ifdef ADLER32_PAR_SEED_EN
    // Continue "Wikipedia" with "abc".
    do_start(0, 32'h11E6_0398);
    send(0, {32'h6162_6300, 32'h0}, 2, 1'b1, -1);
    drain(0);
    chk("seed_final", 0, dato[0], 32'h1EF8_04BE);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
